// File: rtl/axi_store_bridge_if.sv
// AXI4 write-channel bundle (AW, W, B) between the store bridge and memory.
//   master : AW*/W* outputs, BREADY output; AWREADY, WREADY, B* inputs
//   slave  : mirror image of master
interface axi_store_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    logic [3:0]          AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [3:0]          BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/axi_store_bridge.sv
// Store-path bridge: turns one memory-stage store request into a single-beat
// AXI4 write and pulses wdone (with werr) when it completes or is rejected.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mm_wen/addr/wdata/wlen    store request, held until wdone
//   wdone, werr, busy         completion pulse, error flag, in-flight flag
//   axi                       AW/W/B channels (master side)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a store request
// ST_REQ    | AWVALID/WVALID outstanding, each channel tracked separately
// ST_RESP   | both handshakes done, BREADY high, waiting for BVALID
// ST_DONE   | wdone pulse cycle, back to idle next edge
module axi_store_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mm_wen,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [DATA_W-1:0] mm_wdata,
    input  logic [3:0]        mm_wlen,
    output logic              wdone,
    output logic              werr,
    output logic              busy,
    axi_store_bridge_if.master axi
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} state_t;

    state_t              state;
    logic                aw_valid_q;
    logic                w_valid_q;
    logic                b_ready_q;
    logic                aw_done;
    logic                w_done;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;

    logic [2:0]          lane;
    logic [4:0]          end_byte;
    logic [7:0]          strb_base;
    logic                len_ok;
    logic                fits;
    logic                aw_hs;
    logic                w_hs;

    assign lane     = mm_addr[2:0];
    assign end_byte = {2'b00, lane} + {1'b0, mm_wlen};
    assign fits     = (end_byte <= 5'd8);
    assign aw_hs    = aw_valid_q & axi.AWREADY;
    assign w_hs     = w_valid_q & axi.WREADY;

    always_comb begin
        strb_base = 8'h00;
        len_ok    = 1'b1;
        case (mm_wlen)
            4'd1:    strb_base = 8'h01;
            4'd2:    strb_base = 8'h03;
            4'd4:    strb_base = 8'h0F;
            4'd8:    strb_base = 8'hFF;
            default: len_ok    = 1'b0;
        endcase
    end

    assign axi.AWID    = AXI_ID;
    assign axi.AWADDR  = aw_addr_q;
    assign axi.AWLEN   = 8'd0;
    assign axi.AWSIZE  = 3'd3;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = aw_valid_q;
    assign axi.WDATA   = w_data_q;
    assign axi.WSTRB   = w_strb_q;
    assign axi.WLAST   = w_valid_q;
    assign axi.WVALID  = w_valid_q;
    assign axi.BREADY  = b_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wdone      <= 1'b0;
            werr       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mm_wen && !wdone) begin
                        if (len_ok && fits) begin
                            aw_addr_q  <= {mm_addr[ADDR_W-1:3], 3'b000};
                            w_data_q   <= mm_wdata << {lane, 3'b000};
                            w_strb_q   <= strb_base << lane;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done    <= 1'b0;
                            w_done     <= 1'b0;
                            busy       <= 1'b1;
                            state      <= ST_REQ;
                        end else begin
                            // Rejected store completes immediately, no bus traffic.
                            werr  <= 1'b1;
                            wdone <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done    <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        b_ready_q <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (b_ready_q && axi.BVALID) begin
                        werr      <= (axi.BRESP != 2'b00);
                        b_ready_q <= 1'b0;
                        wdone     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wdone <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_store_bridge.sv
module tb_axi_store_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mm_wen;
    logic [63:0] mm_addr;
    logic [63:0] mm_wdata;
    logic [3:0]  mm_wlen;
    logic        wdone;
    logic        werr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_store_bridge_if #(.ADDR_W(64), .DATA_W(64)) axi ();

    axi_store_bridge #(.AXI_ID(4'd1), .ADDR_W(64), .DATA_W(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .mm_wen   (mm_wen),
        .mm_addr  (mm_addr),
        .mm_wdata (mm_wdata),
        .mm_wlen  (mm_wlen),
        .wdone    (wdone),
        .werr     (werr),
        .busy     (busy),
        .axi      (axi)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
        axi.BID     = 4'd0;
    endtask

    // One store: the slave raises AWREADY at cycle 1+aw_d, WREADY at 1+w_d and
    // BVALID from cycle b_at on (cycle 0 = the cycle the request is presented).
    task automatic run_store(input logic [63:0] addr, input logic [63:0] data,
                             input logic [3:0] len, input int aw_d, input int w_d,
                             input int b_at, input logic [1:0] bresp, input string name);
        int          lane, aw_hs, w_hs, both, bdone, done;
        bit          rej, seen;
        bit          e_awv, e_wv, e_br;
        logic [63:0] e_addr, e_data;
        logic [7:0]  e_strb;

        lane   = int'(addr[2:0]);
        rej    = !(len == 4'd1 || len == 4'd2 || len == 4'd4 || len == 4'd8)
                 || (lane + int'(len) > 8);
        e_addr = addr & ~64'h7;
        e_data = data << (8 * lane);
        e_strb = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i >= lane && i < lane + int'(len)) e_strb[i] = 1'b1;
        aw_hs = 1 + aw_d;
        w_hs  = 1 + w_d;
        both  = (aw_hs > w_hs) ? aw_hs : w_hs;
        bdone = (b_at > both + 1) ? b_at : both + 1;
        done  = rej ? 1 : bdone + 1;

        mm_addr  = addr;
        mm_wdata = data;
        mm_wlen  = len;
        mm_wen   = 1'b1;
        slave_idle();
        seen = 1'b0;

        for (int c = 1; c <= done + 4 && !seen; c++) begin
            @(posedge clk); #1;
            axi.AWREADY = (c >= aw_hs);
            axi.WREADY  = (c >= w_hs);
            axi.BVALID  = (c >= b_at);
            axi.BRESP   = bresp;
            axi.BID     = 4'($urandom);

            e_awv = !rej && c <= aw_hs;
            e_wv  = !rej && c <= w_hs;
            e_br  = !rej && c > both && c <= bdone;
            check({name, "/awvalid"}, 64'(axi.AWVALID), 64'(e_awv));
            check({name, "/wvalid"},  64'(axi.WVALID),  64'(e_wv));
            check({name, "/bready"},  64'(axi.BREADY),  64'(e_br));
            check({name, "/busy"},    64'(busy),        64'(!rej && c < done));
            check({name, "/wdone"},   64'(wdone),       64'(c == done));
            if (e_awv) begin
                check({name, "/awaddr"},  axi.AWADDR,        e_addr);
                check({name, "/awid"},    64'(axi.AWID),     64'h1);
                check({name, "/awlen"},   64'(axi.AWLEN),    64'h0);
                check({name, "/awsize"},  64'(axi.AWSIZE),   64'h3);
                check({name, "/awburst"}, 64'(axi.AWBURST),  64'h1);
            end
            if (e_wv) begin
                check({name, "/wdata"}, axi.WDATA,        e_data);
                check({name, "/wstrb"}, 64'(axi.WSTRB),   64'(e_strb));
                check({name, "/wlast"}, 64'(axi.WLAST),   64'h1);
            end
            if (c == 1) begin
                mm_addr  = {$urandom, $urandom};
                mm_wdata = {$urandom, $urandom};
                mm_wlen  = 4'($urandom);
            end
            if (wdone === 1'b1) begin
                seen = 1'b1;
                check({name, "/latency"}, 64'(c), 64'(done));
                check({name, "/werr"}, 64'(werr), 64'(rej || bresp != 2'b00));
                mm_wen = 1'b0;
                slave_idle();
            end
        end
        check({name, "/wdone_seen"}, 64'(seen), 64'h1);
        mm_wen = 1'b0;
        slave_idle();
        @(posedge clk); #1;
        check({name, "/idle_busy"},  64'(busy),  64'h0);
        check({name, "/idle_wdone"}, 64'(wdone), 64'h0);
    endtask

    initial begin
        logic [3:0] lens [12];
        logic [1:0] br;
        lens = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0, 4'd5, 4'd8};

        rst      = 1'b1;
        mm_wen   = 1'b0;
        mm_addr  = 64'h0;
        mm_wdata = 64'h0;
        mm_wlen  = 4'd0;
        slave_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst/awvalid", 64'(axi.AWVALID), 64'h0);
        check("rst/wvalid",  64'(axi.WVALID),  64'h0);
        check("rst/bready",  64'(axi.BREADY),  64'h0);
        check("rst/wdone",   64'(wdone),       64'h0);
        check("rst/werr",    64'(werr),        64'h0);
        check("rst/busy",    64'(busy),        64'h0);
        check("rst/awaddr",  axi.AWADDR,       64'h0);
        check("rst/wdata",   axi.WDATA,        64'h0);
        check("rst/wstrb",   64'(axi.WSTRB),   64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_store(64'h8000_0008, 64'h1122_3344_5566_7788, 4'd8, 0, 0, 1, 2'b00, "aligned8");
        run_store(64'h8000_0013, 64'h0000_0000_0000_00AB, 4'd1, 0, 0, 1, 2'b00, "byte");
        run_store(64'h8000_0020, 64'hDEAD_BEEF_0BAD_F00D, 4'd8, 0, 3, 6, 2'b00, "skewed");
        run_store(64'h8000_0104, 64'h0000_0000_CAFE_BABE, 4'd4, 0, 0, 1, 2'b10, "slverr");
        run_store(64'h8000_0104, 64'h0000_0000_CAFE_BABE, 4'd4, 1, 0, 2, 2'b00, "okay_after_err");
        run_store(64'h8000_0006, 64'h0000_0000_1234_5678, 4'd4, 0, 0, 1, 2'b00, "reject_cross");
        run_store(64'h8000_0000, 64'h0000_0000_0012_3456, 4'd3, 0, 0, 1, 2'b00, "reject_len3");
        run_store(64'h8000_0002, 64'h0000_0000_0000_BEEF, 4'd2, 2, 1, 1, 2'b00, "half_ok");

        // Reset while the W channel is still waiting for WREADY.
        mm_addr  = 64'h8000_0040;
        mm_wdata = 64'h0102_0304_0506_0708;
        mm_wlen  = 4'd8;
        mm_wen   = 1'b1;
        slave_idle();
        @(posedge clk); #1;
        check("midrst/wvalid_before", 64'(axi.WVALID), 64'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst/awvalid", 64'(axi.AWVALID), 64'h0);
        check("midrst/wvalid",  64'(axi.WVALID),  64'h0);
        check("midrst/bready",  64'(axi.BREADY),  64'h0);
        check("midrst/busy",    64'(busy),        64'h0);
        check("midrst/wdone",   64'(wdone),       64'h0);
        check("midrst/wstrb",   64'(axi.WSTRB),   64'h0);
        rst    = 1'b0;
        mm_wen = 1'b0;
        @(posedge clk); #1;
        run_store(64'h8000_0048, 64'hA5A5_5A5A_0F0F_F0F0, 4'd8, 0, 0, 1, 2'b00, "after_rst");

        for (int n = 0; n < 40; n++) begin
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_store({$urandom, $urandom}, {$urandom, $urandom},
                      lens[$urandom_range(0, 11)],
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(1, 8)), br, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
